// File: rtl/br_fifo_shared_pstatic_config_pkg.sv
// Shared types and helpers for the pseudo-static multi-FIFO runtime
// reconfiguration controller.
package br_fifo_shared_pstatic_config_pkg;

  typedef enum logic [1:0] {
    OK        = 2'd0,
    BAD_RANGE = 2'd1,
    TOO_SMALL = 2'd2,
    TIMEOUT   = 2'd3
  } cfg_status_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_DRAIN = 3'd2,
    ST_APPLY = 3'd3,
    ST_RESP  = 3'd4
  } cfg_state_e;

  function automatic int unsigned clamped_clog2(input int unsigned v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction

  function automatic int unsigned default_base(input int unsigned i, input int unsigned depth,
                                               input int unsigned num_fifos);
    return i * (depth / num_fifos);
  endfunction

  // The last FIFO absorbs the remainder when Depth is not a multiple of NumFifos.
  function automatic int unsigned default_bound(input int unsigned i, input int unsigned depth,
                                                input int unsigned num_fifos);
    return (i == num_fifos - 1) ? depth - 1 : (i + 1) * (depth / num_fifos) - 1;
  endfunction

endpackage

// File: rtl/br_fifo_shared_pstatic_config_ctrl_if.sv
// Request/response, drain-status and live-partition signals of the
// reconfiguration controller.
interface br_fifo_shared_pstatic_config_ctrl_if #(
  parameter int unsigned NumFifos = 2,
  parameter int unsigned Depth    = 8
);
  import br_fifo_shared_pstatic_config_pkg::*;

  localparam int unsigned AddrWidth  = clamped_clog2(Depth);
  localparam int unsigned CountWidth = $clog2(Depth + 1);

  logic                                 cfg_valid;
  logic                                 cfg_ready;
  logic [NumFifos-1:0][AddrWidth-1:0]   cfg_base;
  logic [NumFifos-1:0][AddrWidth-1:0]   cfg_bound;
  logic [NumFifos-1:0]                  fifo_empty;
  logic                                 push_block;
  logic [NumFifos-1:0][AddrWidth-1:0]   config_base;
  logic [NumFifos-1:0][AddrWidth-1:0]   config_bound;
  logic [NumFifos-1:0][CountWidth-1:0]  config_size;
  logic                                 resp_valid;
  logic                                 resp_ready;
  cfg_status_e                          resp_status;

  modport master (
    output cfg_valid, cfg_base, cfg_bound, fifo_empty, resp_ready,
    input  cfg_ready, push_block, config_base, config_bound, config_size,
           resp_valid, resp_status
  );

  modport slave (
    input  cfg_valid, cfg_base, cfg_bound, fifo_empty, resp_ready,
    output cfg_ready, push_block, config_base, config_bound, config_size,
           resp_valid, resp_status
  );

endinterface

// File: rtl/br_fifo_shared_pstatic_config_check.sv
// Combinational validator for a requested partition: per-FIFO sizes and an
// overall status, range errors taking priority over size errors.
module br_fifo_shared_pstatic_config_check
  import br_fifo_shared_pstatic_config_pkg::*;
#(
  parameter int unsigned NumFifos = 2,
  parameter int unsigned Depth    = 8,
  parameter int unsigned MinSize  = 1
) (
  input  logic [NumFifos-1:0][clamped_clog2(Depth)-1:0]  base_i,
  input  logic [NumFifos-1:0][clamped_clog2(Depth)-1:0]  bound_i,
  output logic [NumFifos-1:0][$clog2(Depth + 1)-1:0]     size_o,
  output cfg_status_e                                    status_o
);

  localparam int unsigned CountWidth = $clog2(Depth + 1);
  localparam bit          DepthPow2  = ((Depth & (Depth - 1)) == 0);

  logic bad_range;
  logic too_small;

  always_comb begin
    bad_range = 1'b0;
    too_small = 1'b0;
    size_o    = '0;
    for (int unsigned i = 0; i < NumFifos; i++) begin
      size_o[i] = CountWidth'(bound_i[i]) + CountWidth'(1) - CountWidth'(base_i[i]);
      if (base_i[i] > bound_i[i]) bad_range = 1'b1;
      if (size_o[i] < CountWidth'(MinSize)) too_small = 1'b1;
    end
    // Partitions must be strictly ascending and non-overlapping.
    for (int unsigned i = 1; i < NumFifos; i++) begin
      if (base_i[i] <= bound_i[i-1]) bad_range = 1'b1;
    end
    if (!DepthPow2 && (CountWidth'(bound_i[NumFifos-1]) >= CountWidth'(Depth))) bad_range = 1'b1;

    if (bad_range)      status_o = BAD_RANGE;
    else if (too_small) status_o = TOO_SMALL;
    else                status_o = OK;
  end

endmodule

// File: rtl/br_fifo_shared_pstatic_config_ctrl.sv
// Runtime partition controller: validates a request, blocks pushes and drains
// every logical FIFO, then swaps in the new partition atomically.
module br_fifo_shared_pstatic_config_ctrl
  import br_fifo_shared_pstatic_config_pkg::*;
#(
  parameter int unsigned NumFifos     = 2,
  parameter int unsigned Depth        = 8,
  parameter int unsigned MinSize      = 1,
  parameter int unsigned DrainTimeout = 0
) (
  input logic                            clk,
  input logic                            rst,
  br_fifo_shared_pstatic_config_ctrl_if.slave cfg_if
);

  localparam int unsigned AddrWidth  = clamped_clog2(Depth);
  localparam int unsigned CountWidth = $clog2(Depth + 1);
  localparam int unsigned TimerWidth = clamped_clog2(DrainTimeout);

  if ((NumFifos < 1) || (Depth < NumFifos)) begin : g_bad_depth
    $error("Depth must be >= NumFifos >= 1");
  end
  if ((MinSize < 1) || (MinSize > Depth / NumFifos)) begin : g_bad_min_size
    $error("MinSize must lie in 1..Depth/NumFifos");
  end

  cfg_state_e                           state_q;
  logic [NumFifos-1:0][AddrWidth-1:0]   stage_base_q;
  logic [NumFifos-1:0][AddrWidth-1:0]   stage_bound_q;
  logic [NumFifos-1:0][AddrWidth-1:0]   config_base_q;
  logic [NumFifos-1:0][AddrWidth-1:0]   config_bound_q;
  logic [NumFifos-1:0][CountWidth-1:0]  config_size_q;
  cfg_status_e                          status_q;
  logic [TimerWidth-1:0]                timer_q;
  logic                                 guard_q;

  logic [NumFifos-1:0][CountWidth-1:0]  chk_size;
  cfg_status_e                          chk_status;

  br_fifo_shared_pstatic_config_check #(
    .NumFifos (NumFifos),
    .Depth    (Depth),
    .MinSize  (MinSize)
  ) u_check (
    .base_i   (stage_base_q),
    .bound_i  (stage_bound_q),
    .size_o   (chk_size),
    .status_o (chk_status)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      status_q <= OK;
      timer_q  <= '0;
      guard_q  <= 1'b0;
      for (int unsigned i = 0; i < NumFifos; i++) begin
        stage_base_q[i]   <= AddrWidth'(default_base(i, Depth, NumFifos));
        stage_bound_q[i]  <= AddrWidth'(default_bound(i, Depth, NumFifos));
        config_base_q[i]  <= AddrWidth'(default_base(i, Depth, NumFifos));
        config_bound_q[i] <= AddrWidth'(default_bound(i, Depth, NumFifos));
        config_size_q[i]  <= CountWidth'(default_bound(i, Depth, NumFifos)
                                         - default_base(i, Depth, NumFifos) + 1);
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cfg_if.cfg_valid) begin
            stage_base_q  <= cfg_if.cfg_base;
            stage_bound_q <= cfg_if.cfg_bound;
            state_q       <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (chk_status != OK) begin
            status_q <= chk_status;
            state_q  <= ST_RESP;
          end else begin
            timer_q <= '0;
            guard_q <= 1'b1;
            state_q <= ST_DRAIN;
          end
        end
        // Guard cycle lets a push accepted alongside the block settle into fifo_empty.
        ST_DRAIN: begin
          guard_q <= 1'b0;
          if (!guard_q && (&cfg_if.fifo_empty)) begin
            state_q <= ST_APPLY;
          end else if ((DrainTimeout != 0) && (timer_q == TimerWidth'(DrainTimeout - 1))) begin
            status_q <= TIMEOUT;
            state_q  <= ST_RESP;
          end else if (DrainTimeout != 0) begin
            timer_q <= timer_q + TimerWidth'(1);
          end
        end
        ST_APPLY: begin
          config_base_q  <= stage_base_q;
          config_bound_q <= stage_bound_q;
          config_size_q  <= chk_size;
          status_q       <= OK;
          state_q        <= ST_RESP;
        end
        ST_RESP: begin
          if (cfg_if.resp_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_if.cfg_ready    = (state_q == ST_IDLE);
  assign cfg_if.push_block   = (state_q == ST_DRAIN) || (state_q == ST_APPLY);
  assign cfg_if.resp_valid   = (state_q == ST_RESP);
  assign cfg_if.resp_status  = status_q;
  assign cfg_if.config_base  = config_base_q;
  assign cfg_if.config_bound = config_bound_q;
  assign cfg_if.config_size  = config_size_q;

endmodule

// File: tb/tb_br_fifo_shared_pstatic_config_ctrl.sv
// Directed bench for the reconfiguration controller: a 4x16 instance with a
// drain timeout of 8, plus a 4x12 instance for non-power-of-2 range checks.
module tb_br_fifo_shared_pstatic_config_ctrl;
  import br_fifo_shared_pstatic_config_pkg::*;

  localparam int unsigned NF  = 4;
  localparam int unsigned D   = 16;
  localparam int unsigned D12 = 12;
  localparam int unsigned MS  = 2;
  localparam int unsigned DT  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  br_fifo_shared_pstatic_config_ctrl_if #(.NumFifos(NF), .Depth(D))   if16 ();
  br_fifo_shared_pstatic_config_ctrl_if #(.NumFifos(NF), .Depth(D12)) if12 ();

  br_fifo_shared_pstatic_config_ctrl #(
    .NumFifos(NF), .Depth(D), .MinSize(MS), .DrainTimeout(DT)
  ) u_dut (
    .clk    (clk),
    .rst    (rst),
    .cfg_if (if16.slave)
  );

  br_fifo_shared_pstatic_config_ctrl #(
    .NumFifos(NF), .Depth(D12), .MinSize(MS), .DrainTimeout(DT)
  ) u_dut12 (
    .clk    (clk),
    .rst    (rst),
    .cfg_if (if12.slave)
  );

  function automatic logic [15:0] pk4(input int v0, input int v1, input int v2, input int v3);
    return {4'(v3), 4'(v2), 4'(v1), 4'(v0)};
  endfunction

  function automatic logic [19:0] pk5(input int v0, input int v1, input int v2, input int v3);
    return {5'(v3), 5'(v2), 5'(v1), 5'(v0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handshake happens in the current cycle (cycle 0); returns in cycle 1.
  task automatic req16(input logic [15:0] b, input logic [15:0] bd);
    if16.cfg_base  = b;
    if16.cfg_bound = bd;
    if16.cfg_valid = 1'b1;
    tick();
    if16.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    if16.cfg_valid = 1'b0; if16.cfg_base = '0; if16.cfg_bound = '0;
    if16.fifo_empty = 4'hF; if16.resp_ready = 1'b0;
    if12.cfg_valid = 1'b0; if12.cfg_base = '0; if12.cfg_bound = '0;
    if12.fifo_empty = 4'hF; if12.resp_ready = 1'b0;
    rst = 1'b1;
    #12;
    rst = 1'b0;
    tick();
    checks++;
    if (if16.config_base !== pk4(0, 4, 8, 12)) begin
      errors++; $display("FAIL reset_base got %h exp %h", if16.config_base, pk4(0, 4, 8, 12));
    end
    checks++;
    if (if16.config_bound !== pk4(3, 7, 11, 15)) begin
      errors++; $display("FAIL reset_bound got %h exp %h", if16.config_bound, pk4(3, 7, 11, 15));
    end
    checks++;
    if (if16.config_size !== pk5(4, 4, 4, 4)) begin
      errors++; $display("FAIL reset_size got %h exp %h", if16.config_size, pk5(4, 4, 4, 4));
    end
    checks++;
    if ({if16.cfg_ready, if16.push_block, if16.resp_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_ctrl got rdy/blk/rv=%b exp 100",
                         {if16.cfg_ready, if16.push_block, if16.resp_valid});
    end
    checks++;
    if (if16.resp_status !== OK) begin
      errors++; $display("FAIL reset_status got %0d exp 0", if16.resp_status);
    end
  endtask

  task automatic test_ok_path();
    logic exp_blk, exp_rv;
    logic [15:0] exp_base;
    if16.fifo_empty = 4'hF;
    req16(pk4(0, 2, 6, 10), pk4(1, 5, 9, 15));
    for (int c = 1; c <= 5; c++) begin
      exp_blk  = (c >= 2) && (c <= 4);
      exp_rv   = (c == 5);
      exp_base = (c == 5) ? pk4(0, 2, 6, 10) : pk4(0, 4, 8, 12);
      checks++;
      if (if16.push_block !== exp_blk) begin
        errors++; $display("FAIL ok_push_block cyc%0d got %b exp %b", c, if16.push_block, exp_blk);
      end
      checks++;
      if (if16.resp_valid !== exp_rv) begin
        errors++; $display("FAIL ok_resp_valid cyc%0d got %b exp %b", c, if16.resp_valid, exp_rv);
      end
      checks++;
      if (if16.config_base !== exp_base) begin
        errors++; $display("FAIL ok_config_base cyc%0d got %h exp %h", c, if16.config_base, exp_base);
      end
      if (c < 5) tick();
    end
    checks++;
    if (if16.resp_status !== OK) begin
      errors++; $display("FAIL ok_status got %0d exp 0", if16.resp_status);
    end
    checks++;
    if (if16.config_bound !== pk4(1, 5, 9, 15)) begin
      errors++; $display("FAIL ok_bound got %h exp %h", if16.config_bound, pk4(1, 5, 9, 15));
    end
    checks++;
    if (if16.config_size !== pk5(2, 4, 4, 6)) begin
      errors++; $display("FAIL ok_size got %h exp %h", if16.config_size, pk5(2, 4, 4, 6));
    end
    if16.resp_ready = 1'b1;
    tick();
    if16.resp_ready = 1'b0;
    checks++;
    if ({if16.cfg_ready, if16.resp_valid} !== 2'b10) begin
      errors++; $display("FAIL ok_return_idle got rdy/rv=%b exp 10", {if16.cfg_ready, if16.resp_valid});
    end
  endtask

  task automatic test_check_errors();
    logic [15:0] bases [2];
    logic [15:0] bounds[2];
    cfg_status_e exp_st[2];
    bases[0] = pk4(0, 2, 5, 10); bounds[0] = pk4(1, 5, 9, 15); exp_st[0] = BAD_RANGE;
    bases[1] = pk4(0, 1, 6, 10); bounds[1] = pk4(0, 5, 9, 15); exp_st[1] = TOO_SMALL;
    for (int k = 0; k < 2; k++) begin
      req16(bases[k], bounds[k]);
      checks++;
      if ({if16.push_block, if16.resp_valid} !== 2'b00) begin
        errors++; $display("FAIL err%0d_cyc1 got blk/rv=%b exp 00", k, {if16.push_block, if16.resp_valid});
      end
      tick();
      checks++;
      if ({if16.push_block, if16.resp_valid} !== 2'b01) begin
        errors++; $display("FAIL err%0d_cyc2 got blk/rv=%b exp 01", k, {if16.push_block, if16.resp_valid});
      end
      checks++;
      if (if16.resp_status !== exp_st[k]) begin
        errors++; $display("FAIL err%0d_status got %0d exp %0d", k, if16.resp_status, exp_st[k]);
      end
      checks++;
      if ({if16.config_base, if16.config_bound} !== {pk4(0, 2, 6, 10), pk4(1, 5, 9, 15)}) begin
        errors++; $display("FAIL err%0d_config got %h/%h exp unchanged", k, if16.config_base, if16.config_bound);
      end
      if16.resp_ready = 1'b1;
      tick();
      if16.resp_ready = 1'b0;
    end
  endtask

  task automatic test_timeout();
    logic exp_blk, exp_rv;
    if16.fifo_empty = 4'b1011;
    req16(pk4(0, 4, 8, 12), pk4(3, 7, 11, 15));
    for (int c = 1; c <= 10; c++) begin
      exp_blk = (c >= 2) && (c <= 9);
      exp_rv  = (c == 10);
      checks++;
      if ({if16.push_block, if16.resp_valid} !== {exp_blk, exp_rv}) begin
        errors++; $display("FAIL timeout_cyc%0d got blk/rv=%b exp %b", c,
                           {if16.push_block, if16.resp_valid}, {exp_blk, exp_rv});
      end
      if (c < 10) tick();
    end
    checks++;
    if (if16.resp_status !== TIMEOUT) begin
      errors++; $display("FAIL timeout_status got %0d exp 3", if16.resp_status);
    end
    checks++;
    if (if16.config_base !== pk4(0, 2, 6, 10)) begin
      errors++; $display("FAIL timeout_config got %h exp %h", if16.config_base, pk4(0, 2, 6, 10));
    end
    if16.resp_ready = 1'b1;
    tick();
    if16.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    if16.fifo_empty = 4'b1011;
    req16(pk4(0, 4, 8, 12), pk4(3, 7, 11, 15));
    tick();
    tick();
    checks++;
    if (if16.push_block !== 1'b1) begin
      errors++; $display("FAIL rstdrain_pre_block got %b exp 1", if16.push_block);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({if16.push_block, if16.resp_valid, if16.cfg_ready} !== 3'b001) begin
      errors++; $display("FAIL rstdrain_ctrl got blk/rv/rdy=%b exp 001",
                         {if16.push_block, if16.resp_valid, if16.cfg_ready});
    end
    checks++;
    if ({if16.config_base, if16.config_bound} !== {pk4(0, 4, 8, 12), pk4(3, 7, 11, 15)}) begin
      errors++; $display("FAIL rstdrain_config got %h/%h exp default", if16.config_base, if16.config_bound);
    end
    #1 rst = 1'b0;
    tick();
    checks++;
    if ({if16.resp_valid, if16.cfg_ready} !== 2'b01) begin
      errors++; $display("FAIL rstdrain_after got rv/rdy=%b exp 01", {if16.resp_valid, if16.cfg_ready});
    end
  endtask

  task automatic test_late_drain();
    logic exp_blk, exp_rv;
    logic [15:0] exp_base;
    if16.fifo_empty = 4'b1011;
    req16(pk4(0, 2, 6, 10), pk4(1, 5, 9, 15));
    for (int c = 1; c <= 7; c++) begin
      if (c == 5) if16.fifo_empty = 4'hF;
      exp_blk  = (c >= 2) && (c <= 6);
      exp_rv   = (c == 7);
      exp_base = (c == 7) ? pk4(0, 2, 6, 10) : pk4(0, 4, 8, 12);
      checks++;
      if ({if16.push_block, if16.resp_valid} !== {exp_blk, exp_rv}) begin
        errors++; $display("FAIL late_cyc%0d got blk/rv=%b exp %b", c,
                           {if16.push_block, if16.resp_valid}, {exp_blk, exp_rv});
      end
      checks++;
      if (if16.config_base !== exp_base) begin
        errors++; $display("FAIL late_base_cyc%0d got %h exp %h", c, if16.config_base, exp_base);
      end
      if (c < 7) tick();
    end
    checks++;
    if ({if16.resp_status, if16.config_size} !== {OK, pk5(2, 4, 4, 6)}) begin
      errors++; $display("FAIL late_status_size got %0d/%h exp 0/%h", if16.resp_status,
                         if16.config_size, pk5(2, 4, 4, 6));
    end
    if16.resp_ready = 1'b1;
    tick();
    if16.resp_ready = 1'b0;
  endtask

  task automatic test_back_pressure();
    req16(pk4(0, 2, 5, 10), pk4(1, 5, 9, 15));
    tick();
    // Offer a second, legal request while the response is stalled.
    if16.cfg_base  = pk4(0, 4, 8, 12);
    if16.cfg_bound = pk4(3, 7, 11, 15);
    if16.cfg_valid = 1'b1;
    for (int c = 2; c <= 4; c++) begin
      checks++;
      if ({if16.resp_valid, if16.cfg_ready, if16.resp_status} !== {2'b10, BAD_RANGE}) begin
        errors++; $display("FAIL bp_hold_cyc%0d got rv/rdy/st=%b exp 1001", c,
                           {if16.resp_valid, if16.cfg_ready, if16.resp_status});
      end
      tick();
    end
    if16.cfg_valid  = 1'b0;
    if16.resp_ready = 1'b1;
    tick();
    if16.resp_ready = 1'b0;
    checks++;
    if ({if16.resp_valid, if16.cfg_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release got rv/rdy=%b exp 01", {if16.resp_valid, if16.cfg_ready});
    end
    checks++;
    if (if16.config_base !== pk4(0, 2, 6, 10)) begin
      errors++; $display("FAIL bp_config got %h exp %h", if16.config_base, pk4(0, 2, 6, 10));
    end
  endtask

  task automatic test_depth12();
    checks++;
    if ({if12.config_base, if12.config_bound, if12.config_size}
        !== {pk4(0, 3, 6, 9), pk4(2, 5, 8, 11), pk4(3, 3, 3, 3)}) begin
      errors++; $display("FAIL d12_default got %h/%h/%h exp 9630/b852/3333",
                         if12.config_base, if12.config_bound, if12.config_size);
    end
    if12.cfg_base  = pk4(0, 3, 6, 9);
    if12.cfg_bound = pk4(2, 5, 8, 12);
    if12.cfg_valid = 1'b1;
    tick();
    if12.cfg_valid = 1'b0;
    tick();
    checks++;
    if ({if12.resp_valid, if12.push_block, if12.resp_status} !== {2'b10, BAD_RANGE}) begin
      errors++; $display("FAIL d12_bad_range got rv/blk/st=%b exp 1001",
                         {if12.resp_valid, if12.push_block, if12.resp_status});
    end
    if12.resp_ready = 1'b1;
    tick();
    if12.resp_ready = 1'b0;
    checks++;
    if ({if12.cfg_ready, if12.config_bound} !== {1'b1, pk4(2, 5, 8, 11)}) begin
      errors++; $display("FAIL d12_after got rdy=%b bound=%h exp 1/b852", if12.cfg_ready, if12.config_bound);
    end
  endtask

  initial begin
    test_reset();
    test_ok_path();
    test_check_errors();
    test_timeout();
    test_reset_mid_drain();
    test_late_drain();
    test_back_pressure();
    test_depth12();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
